// File: rtl/vreg_resolver.sv
// Register-resolution responder: maps virtual to physical registers, allocates
// destinations from a free bitmap, tracks preg valid/data, and checkpoints the map per context.
module vreg_resolver #(
    parameter int unsigned LEN_VREG_ADDR = 5,
    parameter int unsigned LEN_PREG_ADDR = 6,
    parameter int unsigned LEN_WORD      = 32,
    parameter int unsigned LEN_CONTEXT   = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     req_rs1_order,
    input  logic                     req_rs2_order,
    input  logic                     req_rd_order,
    input  logic [LEN_VREG_ADDR-1:0] req_va_rs1,
    input  logic [LEN_VREG_ADDR-1:0] req_va_rs2,
    input  logic [LEN_VREG_ADDR-1:0] req_va_rd,
    input  logic [LEN_CONTEXT-1:0]   req_context,
    output logic                     rsp_rs1_ready,
    output logic                     rsp_rs2_ready,
    output logic [LEN_WORD-1:0]      rsp_d_rs1,
    output logic [LEN_WORD-1:0]      rsp_d_rs2,
    output logic                     rsp_rd_ready,
    output logic [LEN_PREG_ADDR-1:0] rsp_pa_rd,
    output logic                     rsp_flag,
    input  logic                     wb_en,
    input  logic [LEN_PREG_ADDR-1:0] wb_pa,
    input  logic [LEN_WORD-1:0]      wb_data,
    input  logic                     rel_en,
    input  logic [LEN_PREG_ADDR-1:0] rel_pa,
    input  logic                     ckpt_en,
    input  logic [LEN_CONTEXT-1:0]   ckpt_context,
    input  logic                     branch_hazard,
    input  logic [LEN_CONTEXT-1:0]   hazard_context_info
);

    localparam int unsigned NUM_VREG = 1 << LEN_VREG_ADDR;
    localparam int unsigned NUM_PREG = 1 << LEN_PREG_ADDR;

    logic [LEN_PREG_ADDR-1:0] map_q    [NUM_VREG];
    logic [LEN_PREG_ADDR-1:0] map_next [NUM_VREG];
    logic [LEN_PREG_ADDR-1:0] ckpt_q   [LEN_CONTEXT][NUM_VREG];
    logic [LEN_WORD-1:0]      pdata_q  [NUM_PREG];
    logic [NUM_PREG-1:0]      pval_q;
    logic [NUM_PREG-1:0]      free_q;

    logic                     kill;
    logic                     any_free;
    logic                     alloc;
    logic [LEN_PREG_ADDR-1:0] free_pa;
    logic [LEN_PREG_ADDR-1:0] pa_rs1;
    logic [LEN_PREG_ADDR-1:0] pa_rs2;

    function automatic logic [LEN_WORD:0] read_operand(
        input logic                     order,
        input logic [LEN_VREG_ADDR-1:0] va,
        input logic                     wb_hit,
        input logic                     valid,
        input logic [LEN_WORD-1:0]      data
    );
        if (!order)          return '0;
        else if (va == '0)   return {1'b1, {LEN_WORD{1'b0}}};
        else if (wb_hit)     return {1'b1, wb_data};
        else if (valid)      return {1'b1, data};
        else                 return '0;
    endfunction

    assign kill     = branch_hazard & |(hazard_context_info & req_context);
    assign any_free = |free_q;
    assign alloc    = req_rd_order & (req_va_rd != '0) & any_free & ~kill;
    assign pa_rs1   = map_q[req_va_rs1];
    assign pa_rs2   = map_q[req_va_rs2];

    // Downward scan so the lowest-index free preg is the last (winning) assignment.
    always_comb begin
        free_pa = '0;
        for (int unsigned p = NUM_PREG; p > 0; p--) begin
            if (free_q[p-1]) free_pa = LEN_PREG_ADDR'(p - 1);
        end
    end

    assign {rsp_rs1_ready, rsp_d_rs1} = read_operand(req_rs1_order, req_va_rs1,
        wb_en && (wb_pa == pa_rs1), pval_q[pa_rs1], pdata_q[pa_rs1]);
    assign {rsp_rs2_ready, rsp_d_rs2} = read_operand(req_rs2_order, req_va_rs2,
        wb_en && (wb_pa == pa_rs2), pval_q[pa_rs2], pdata_q[pa_rs2]);

    assign rsp_rd_ready = req_rd_order & ((req_va_rd == '0) | (any_free & ~kill));
    assign rsp_pa_rd    = alloc ? free_pa : '0;
    assign rsp_flag     = (req_rs1_order | req_rs2_order | req_rd_order) & ~kill;

    // Restore first, then the surviving allocation on top; checkpoints capture the result.
    always_comb begin
        for (int unsigned v = 0; v < NUM_VREG; v++) map_next[v] = map_q[v];
        if (branch_hazard) begin
            for (int unsigned c = 0; c < LEN_CONTEXT; c++) begin
                if (hazard_context_info[c]) begin
                    for (int unsigned v = 0; v < NUM_VREG; v++) map_next[v] = ckpt_q[c][v];
                end
            end
        end
        if (alloc) map_next[req_va_rd] = free_pa;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned v = 0; v < NUM_VREG; v++) map_q[v] <= LEN_PREG_ADDR'(v);
            for (int unsigned c = 0; c < LEN_CONTEXT; c++) begin
                for (int unsigned v = 0; v < NUM_VREG; v++) ckpt_q[c][v] <= LEN_PREG_ADDR'(v);
            end
            pval_q <= '1;
            for (int unsigned p = 0; p < NUM_PREG; p++) begin
                pdata_q[p] <= '0;
                free_q[p]  <= (p >= NUM_VREG);
            end
        end else begin
            for (int unsigned v = 0; v < NUM_VREG; v++) map_q[v] <= map_next[v];
            for (int unsigned c = 0; c < LEN_CONTEXT; c++) begin
                if (ckpt_en && ckpt_context[c]) begin
                    for (int unsigned v = 0; v < NUM_VREG; v++) ckpt_q[c][v] <= map_next[v];
                end
            end
            if (wb_en) begin
                pdata_q[wb_pa] <= wb_data;
                pval_q[wb_pa]  <= 1'b1;
            end
            if (rel_en) free_q[rel_pa] <= 1'b1;
            // Allocation comes last so it overrides a same-cycle writeback to that preg.
            if (alloc) begin
                free_q[free_pa] <= 1'b0;
                pval_q[free_pa] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vreg_resolver.sv
// Directed bench for vreg_resolver: expected responses are queued when a request
// is driven and popped when the combinational response is sampled on the falling edge.
module tb_vreg_resolver;

    localparam int unsigned LV = 5;
    localparam int unsigned LP = 6;
    localparam int unsigned LW = 32;
    localparam int unsigned LC = 2;

    logic          clk = 1'b0;
    logic          rstn;
    logic          req_rs1_order, req_rs2_order, req_rd_order;
    logic [LV-1:0] req_va_rs1, req_va_rs2, req_va_rd;
    logic [LC-1:0] req_context;
    logic          rsp_rs1_ready, rsp_rs2_ready;
    logic [LW-1:0] rsp_d_rs1, rsp_d_rs2;
    logic          rsp_rd_ready;
    logic [LP-1:0] rsp_pa_rd;
    logic          rsp_flag;
    logic          wb_en;
    logic [LP-1:0] wb_pa;
    logic [LW-1:0] wb_data;
    logic          rel_en;
    logic [LP-1:0] rel_pa;
    logic          ckpt_en;
    logic [LC-1:0] ckpt_context;
    logic          branch_hazard;
    logic [LC-1:0] hazard_context_info;

    always #5 clk = ~clk;

    vreg_resolver #(
        .LEN_VREG_ADDR(LV),
        .LEN_PREG_ADDR(LP),
        .LEN_WORD     (LW),
        .LEN_CONTEXT  (LC)
    ) dut (
        .clk                (clk),
        .rstn               (rstn),
        .req_rs1_order      (req_rs1_order),
        .req_rs2_order      (req_rs2_order),
        .req_rd_order       (req_rd_order),
        .req_va_rs1         (req_va_rs1),
        .req_va_rs2         (req_va_rs2),
        .req_va_rd          (req_va_rd),
        .req_context        (req_context),
        .rsp_rs1_ready      (rsp_rs1_ready),
        .rsp_rs2_ready      (rsp_rs2_ready),
        .rsp_d_rs1          (rsp_d_rs1),
        .rsp_d_rs2          (rsp_d_rs2),
        .rsp_rd_ready       (rsp_rd_ready),
        .rsp_pa_rd          (rsp_pa_rd),
        .rsp_flag           (rsp_flag),
        .wb_en              (wb_en),
        .wb_pa              (wb_pa),
        .wb_data            (wb_data),
        .rel_en             (rel_en),
        .rel_pa             (rel_pa),
        .ckpt_en            (ckpt_en),
        .ckpt_context       (ckpt_context),
        .branch_hazard      (branch_hazard),
        .hazard_context_info(hazard_context_info)
    );

    typedef struct {
        string         tag;
        logic          r1;
        logic [LW-1:0] d1;
        logic          r2;
        logic [LW-1:0] d2;
        logic          rdr;
        logic [LP-1:0] pa;
        logic          flag;
    } exp_t;

    exp_t sb[$];
    int   n_asserts = 0;
    int   n_fail    = 0;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_inputs();
        req_rs1_order = 1'b0; req_rs2_order = 1'b0; req_rd_order = 1'b0;
        req_va_rs1 = '0; req_va_rs2 = '0; req_va_rd = '0; req_context = '0;
        wb_en = 1'b0; wb_pa = '0; wb_data = '0;
        rel_en = 1'b0; rel_pa = '0;
        ckpt_en = 1'b0; ckpt_context = '0;
        branch_hazard = 1'b0; hazard_context_info = '0;
    endtask

    task automatic set_req(input logic o1, input logic [LV-1:0] v1, input logic o2,
                           input logic [LV-1:0] v2, input logic od, input logic [LV-1:0] vd,
                           input logic [LC-1:0] ctx);
        clear_inputs();
        req_rs1_order = o1; req_va_rs1 = v1;
        req_rs2_order = o2; req_va_rs2 = v2;
        req_rd_order  = od; req_va_rd  = vd;
        req_context   = ctx;
    endtask

    task automatic expect_rsp(input string tag, input logic r1, input logic [LW-1:0] d1,
                              input logic r2, input logic [LW-1:0] d2, input logic rdr,
                              input logic [LP-1:0] pa, input logic flag);
        exp_t e;
        e.tag = tag; e.r1 = r1; e.d1 = d1; e.r2 = r2; e.d2 = d2;
        e.rdr = rdr; e.pa = pa; e.flag = flag;
        sb.push_back(e);
    endtask

    // Sample at the falling edge, then commit the cycle at the rising edge.
    task automatic check_cycle();
        exp_t e;
        @(negedge clk);
        e = sb.pop_front();
        chk({e.tag, ".rs1_ready"}, LW'(rsp_rs1_ready), LW'(e.r1));
        chk({e.tag, ".d_rs1"},     rsp_d_rs1,          e.d1);
        chk({e.tag, ".rs2_ready"}, LW'(rsp_rs2_ready), LW'(e.r2));
        chk({e.tag, ".d_rs2"},     rsp_d_rs2,          e.d2);
        chk({e.tag, ".rd_ready"},  LW'(rsp_rd_ready),  LW'(e.rdr));
        chk({e.tag, ".pa_rd"},     LW'(rsp_pa_rd),     LW'(e.pa));
        chk({e.tag, ".flag"},      LW'(rsp_flag),      LW'(e.flag));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
    endtask

    initial begin
        clear_inputs();
        rstn = 1'b0;
        #1;
        // Responses follow the reset state while reset is held.
        set_req(1, 5'd9, 0, 0, 1, 5'd3, 2'b01);
        expect_rsp("in_reset", 1, 0, 0, 0, 1, 6'd32, 1);
        check_cycle();
        rstn = 1'b1;

        set_req(1, 5'd5, 1, 5'd0, 0, 0, 2'b01);
        expect_rsp("rs_after_reset", 1, 0, 1, 0, 0, 0, 1);
        check_cycle();

        set_req(0, 0, 0, 0, 1, 5'd3, 2'b01);
        expect_rsp("alloc_v3", 0, 0, 0, 0, 1, 6'd32, 1);
        check_cycle();

        set_req(1, 5'd3, 0, 0, 0, 0, 2'b01);
        expect_rsp("v3_pending", 0, 0, 0, 0, 0, 0, 1);
        check_cycle();

        set_req(1, 5'd3, 0, 0, 0, 0, 2'b01);
        wb_en = 1'b1; wb_pa = 6'd32; wb_data = 32'hDEADBEEF;
        expect_rsp("v3_bypass", 1, 32'hDEADBEEF, 0, 0, 0, 0, 1);
        check_cycle();

        set_req(1, 5'd3, 1, 5'd3, 0, 0, 2'b01);
        expect_rsp("v3_stored", 1, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 0, 1);
        check_cycle();

        set_req(0, 0, 0, 0, 0, 0, 2'b01);
        expect_rsp("no_order", 0, 0, 0, 0, 0, 0, 0);
        check_cycle();

        // Mid-operation reset returns the identity map and the upper free pool.
        do_reset();
        set_req(1, 5'd3, 0, 0, 1, 5'd8, 2'b01);
        expect_rsp("post_reset", 1, 0, 0, 0, 1, 6'd32, 1);
        check_cycle();

        do_reset();
        for (int i = 0; i < 32; i++) begin
            set_req(0, 0, 0, 0, 1, LV'((i % 31) + 1), 2'b01);
            expect_rsp($sformatf("fill%0d", i), 0, 0, 0, 0, 1, LP'(32 + i), 1);
            check_cycle();
        end

        set_req(0, 0, 0, 0, 1, 5'd5, 2'b01);
        expect_rsp("pool_empty", 0, 0, 0, 0, 0, 0, 1);
        check_cycle();

        set_req(0, 0, 0, 0, 1, 5'd0, 2'b01);
        expect_rsp("rd_v0_empty", 0, 0, 0, 0, 1, 0, 1);
        check_cycle();

        set_req(0, 0, 0, 0, 1, 5'd6, 2'b01);
        rel_en = 1'b1; rel_pa = 6'd40;
        expect_rsp("rel_same_cycle", 0, 0, 0, 0, 0, 0, 1);
        check_cycle();

        set_req(0, 0, 0, 0, 1, 5'd6, 2'b01);
        expect_rsp("rel_next_cycle", 0, 0, 0, 0, 1, 6'd40, 1);
        check_cycle();

        set_req(0, 0, 0, 0, 1, 5'd7, 2'b01);
        expect_rsp("pool_empty2", 0, 0, 0, 0, 0, 0, 1);
        check_cycle();

        // Same-cycle rs1/rd on v7 and a writeback to the preg being allocated.
        do_reset();
        set_req(1, 5'd7, 0, 0, 1, 5'd7, 2'b01);
        wb_en = 1'b1; wb_pa = 6'd32; wb_data = 32'h0000_1234;
        expect_rsp("rs_rd_same_v", 1, 0, 0, 0, 1, 6'd32, 1);
        check_cycle();

        set_req(1, 5'd7, 0, 0, 0, 0, 2'b01);
        expect_rsp("alloc_beats_wb", 0, 0, 0, 0, 0, 0, 1);
        check_cycle();

        // Checkpoint and restore.
        do_reset();
        set_req(0, 0, 0, 0, 1, 5'd2, 2'b01);
        expect_rsp("ck_alloc_v2", 0, 0, 0, 0, 1, 6'd32, 1);
        check_cycle();

        set_req(0, 0, 0, 0, 0, 0, 2'b01);
        ckpt_en = 1'b1; ckpt_context = 2'b01;
        wb_en = 1'b1; wb_pa = 6'd32; wb_data = 32'hAAAA0001;
        expect_rsp("ck_take", 0, 0, 0, 0, 0, 0, 0);
        check_cycle();

        set_req(0, 0, 0, 0, 1, 5'd2, 2'b10);
        expect_rsp("ck_realloc_v2", 0, 0, 0, 0, 1, 6'd33, 1);
        check_cycle();

        set_req(0, 0, 0, 0, 1, 5'd4, 2'b10);
        branch_hazard = 1'b1; hazard_context_info = 2'b01;
        expect_rsp("hz_survivor", 0, 0, 0, 0, 1, 6'd34, 1);
        check_cycle();

        set_req(1, 5'd2, 1, 5'd4, 0, 0, 2'b10);
        wb_en = 1'b1; wb_pa = 6'd34; wb_data = 32'h0000_0055;
        expect_rsp("hz_restored", 1, 32'hAAAA0001, 1, 32'h0000_0055, 0, 0, 1);
        check_cycle();

        set_req(1, 5'd4, 0, 0, 1, 5'd5, 2'b10);
        branch_hazard = 1'b1; hazard_context_info = 2'b10;
        expect_rsp("hz_killed", 1, 32'h0000_0055, 0, 0, 0, 0, 0);
        check_cycle();

        set_req(1, 5'd2, 0, 0, 1, 5'd6, 2'b01);
        expect_rsp("hz_after_kill", 1, 0, 0, 0, 1, 6'd35, 1);
        check_cycle();

        n_asserts++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
